ring_ctrl: RTL and testbench

Alarm ring sequencer for the RTC display. Compares the running BCD time against the programmed alarm and runs the ring session. It produces the enable that gates the on-screen bell/ring icon renderer (its `okmaquina` input) and a blink/buzzer phase. It also handles stop, snooze with a bounded retry count, and automatic timeout. The block sits between the RTC counter/alarm registers and the VGA text/icon renderers.

---
 rtl/ring_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ring_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ring_ctrl.sv
// Alarm ring sequencer: detects the BCD alarm match and runs the ring/snooze session,
// producing the ring-icon enable, blink phase and buzzer drive.
module ring_ctrl #(
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned SNOOZE_SEC   = 300,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter int unsigned BLINK_DIV    = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring_active,
  output logic       ring_visible,
  output logic       buzzer,
  output logic       ring_event,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT);
  localparam logic [8:0] SNZ_LAST  = 9'(SNOOZE_SEC);
  localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         ring_cnt_q, ring_cnt_d;
  logic [8:0]         snz_tmr_q, snz_tmr_d;
  logic [2:0]         snooze_cnt_q, snooze_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               ring_active_q, ring_active_d;
  logic               ring_visible_q, ring_visible_d;
  logic               buzzer_q, buzzer_d;
  logic               ring_event_q, ring_event_d;
  logic               ring_entry;
  logic               match;
  logic [7:0]         ring_cnt_inc;
  logic [8:0]         snz_tmr_inc;

  assign match = tick_1hz & alarm_en & (hour == alarm_hour) &
                 (min == alarm_min) & (sec == 8'h00);
  assign ring_cnt_inc = ring_cnt_q + 8'd1;
  assign snz_tmr_inc  = snz_tmr_q + 9'd1;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ring_cnt_q     <= '0;
      snz_tmr_q      <= '0;
      snooze_cnt_q   <= '0;
      blink_cnt_q    <= '0;
      ring_active_q  <= 1'b0;
      ring_visible_q <= 1'b0;
      buzzer_q       <= 1'b0;
      ring_event_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_tmr_q      <= snz_tmr_d;
      snooze_cnt_q   <= snooze_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      ring_active_q  <= ring_active_d;
      ring_visible_q <= ring_visible_d;
      buzzer_q       <= buzzer_d;
      ring_event_q   <= ring_event_d;
    end
  end

  // Next-state: alarm_en drop > stop > snooze > tick expiry
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_tmr_d    = snz_tmr_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_entry   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (match) begin
          state_d      = S_RINGING;
          snooze_cnt_d = '0;
          ring_cnt_d   = '0;
          ring_entry   = 1'b1;
        end
      end
      S_RINGING: begin
        if (!alarm_en || stop) begin
          state_d = S_IDLE;
        end else if (snooze) begin
          if (snooze_cnt_q < SNZ_MAX) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
            snz_tmr_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick_1hz) begin
          ring_cnt_d = ring_cnt_inc;
          if (ring_cnt_inc == RING_LAST) state_d = S_IDLE;
        end
      end
      S_SNOOZE: begin
        if (!alarm_en || stop) begin
          state_d = S_IDLE;
        end else if (tick_1hz) begin
          snz_tmr_d = snz_tmr_inc;
          if (snz_tmr_inc == SNZ_LAST) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
            ring_entry = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; blink restarts visible on every ring entry
  always_comb begin
    ring_active_d  = (state_d == S_RINGING);
    ring_event_d   = ring_entry;
    ring_visible_d = ring_visible_q;
    blink_cnt_d    = blink_cnt_q;
    if (state_d != S_RINGING) begin
      ring_visible_d = 1'b0;
      blink_cnt_d    = '0;
    end else if (ring_entry) begin
      ring_visible_d = 1'b1;
      blink_cnt_d    = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      ring_visible_d = ~ring_visible_q;
      blink_cnt_d    = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
    buzzer_d = ring_active_d & ring_visible_d;
  end

  assign state        = state_q;
  assign snooze_cnt   = snooze_cnt_q;
  assign ring_active  = ring_active_q;
  assign ring_visible = ring_visible_q;
  assign buzzer       = buzzer_q;
  assign ring_event   = ring_event_q;

endmodule

// File: tb/tb_ring_ctrl.sv
// Directed bench for ring_ctrl with short timeouts; expected values hand-computed.
module tb_ring_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [7:0] hour = 8'h07;
  logic [7:0] min = 8'h30;
  logic [7:0] sec = 8'h01;
  logic [7:0] alarm_hour = 8'h07;
  logic [7:0] alarm_min = 8'h30;
  logic       alarm_en = 1'b1;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ring_active, ring_visible, buzzer, ring_event;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ring_ctrl #(
    .RING_TIMEOUT(5), .SNOOZE_SEC(3), .MAX_SNOOZE(2), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .hour(hour), .min(min), .sec(sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .stop(stop), .snooze(snooze),
    .ring_active(ring_active), .ring_visible(ring_visible), .buzzer(buzzer),
    .ring_event(ring_event), .state(state), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, then drop one-cycle pulses
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    stop     = 1'b0;
    snooze   = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
  endtask

  task automatic ring_up();
    sec = 8'h00;
    tick_1hz = 1'b1;
    cyc();
    sec = 8'h01;
  endtask

  initial begin
    int blink_exp [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

    cyc(); cyc();
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_active", ring_active, 0);
    check("rst_visible", ring_visible, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_event", ring_event, 0);
    check("rst_snzcnt", snooze_cnt, 0);

    // Basic match and automatic timeout
    ring_up();
    check("m_event", ring_event, 1);
    check("m_state", state, 1);
    check("m_active", ring_active, 1);
    check("m_visible", ring_visible, 1);
    check("m_buzzer", buzzer, 1);
    cyc();
    check("m_event_low", ring_event, 0);
    for (int i = 0; i < 4; i++) tick();
    check("to_4_state", state, 1);
    tick();
    check("to_5_state", state, 0);
    check("to_5_active", ring_active, 0);

    // Snooze, re-ring, counter restarted
    ring_up();
    tick(); tick();
    snooze = 1'b1; cyc();
    check("sz_state", state, 2);
    check("sz_cnt", snooze_cnt, 1);
    check("sz_buzzer", buzzer, 0);
    tick(); tick();
    check("sz_2_state", state, 2);
    tick();
    check("rr_state", state, 1);
    check("rr_event", ring_event, 1);
    for (int i = 0; i < 4; i++) tick();
    check("rr_4_state", state, 1);
    tick();
    check("rr_5_state", state, 0);

    // Snooze limit, with a match tick while snoozing
    ring_up();
    check("lim_cnt0", snooze_cnt, 0);
    snooze = 1'b1; cyc();
    tick(); tick(); tick();
    check("lim_rr1", state, 1);
    snooze = 1'b1; cyc();
    check("lim_cnt2", snooze_cnt, 2);
    ring_up();
    check("snz_match_event", ring_event, 0);
    check("snz_match_state", state, 2);
    check("snz_match_cnt", snooze_cnt, 2);
    tick(); tick();
    check("lim_rr2", state, 1);
    snooze = 1'b1; cyc();
    check("lim_stop_state", state, 0);
    check("lim_stop_cnt", snooze_cnt, 2);

    // Snooze beats a timeout tick in the same cycle
    ring_up();
    for (int i = 0; i < 4; i++) tick();
    snooze = 1'b1; tick_1hz = 1'b1; cyc();
    check("prio_sz_tick", state, 2);
    stop = 1'b1; cyc();
    check("snz_stop", state, 0);

    // Blink pattern with no ticks
    ring_up();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("blink_vis%0d", i), ring_visible, blink_exp[i]);
      check($sformatf("blink_buz%0d", i), buzzer, blink_exp[i]);
      cyc();
    end
    stop = 1'b1; cyc();
    check("stop_state", state, 0);
    check("stop_buzzer", buzzer, 0);

    // Stop and snooze together
    ring_up();
    stop = 1'b1; snooze = 1'b1; cyc();
    check("stop_snz_state", state, 0);

    // alarm_en dropped while snoozing
    ring_up();
    snooze = 1'b1; cyc();
    check("en_pre", state, 2);
    alarm_en = 1'b0; cyc();
    check("en_drop", state, 0);

    // No ring when disarmed or seconds not zero
    ring_up();
    check("dis_state", state, 0);
    check("dis_event", ring_event, 0);
    alarm_en = 1'b1;
    tick_1hz = 1'b1; cyc();
    check("sec01_state", state, 0);

    // Reset mid-session, match in the reset cycle is lost
    ring_up();
    snooze = 1'b1; cyc();
    tick(); tick(); tick();
    check("rs_pre_state", state, 1);
    check("rs_pre_cnt", snooze_cnt, 1);
    reset = 1'b1; sec = 8'h00; tick_1hz = 1'b1; cyc();
    sec = 8'h01;
    check("rs_state", state, 0);
    check("rs_active", ring_active, 0);
    check("rs_visible", ring_visible, 0);
    check("rs_buzzer", buzzer, 0);
    check("rs_event", ring_event, 0);
    check("rs_cnt", snooze_cnt, 0);
    reset = 1'b0; cyc();
    check("rs_lost", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
